// File: rtl/hls_macc_n_obf.sv
// hls_macc_n_obf
//   Key-locked N-lane signed multiply-accumulate behind an ap_ctrl_hs
//   handshake. out_acc = acc_in + sum(a[i]*b[i]), one lane per cycle.
//   The FSM and datapath are gated by a latched locking key. A wrong key
//   gives a deterministic, bit-specific corrupted result and never stalls
//   the controller.
//
// Ports
//   ap_clk, ap_rst      clock, asynchronous active-high reset
//   ap_start            start request, sampled only while idle
//   ap_done/ap_ready    one-cycle pulse while the result is presented
//   ap_idle             high only in S_IDLE
//   locking_key         unlocking key, latched when a start is accepted
//   lane_a, lane_b      N packed signed DW-bit operands, lane i at [i*DW +: DW]
//   acc_in              signed initial accumulator value
//   out_acc             result, held until the next completion
//   out_acc_ap_vld      one-cycle pulse together with ap_done
//
// state  | meaning
// S_IDLE | waiting for ap_start, key latched on acceptance
// S_LOAD | operands and initial accumulator captured
// S_MAC  | one lane multiplied and accumulated per cycle
// S_DONE | result presented, done/ready/vld pulse high
`timescale 1ns/1ps

module hls_macc_n_obf #(
    parameter int N = 4,
    parameter int DW = 8,
    parameter int AW = 32,
    parameter int KEY_W = 8,
    parameter logic [KEY_W-1:0] KEY_VALUE = 8'hA5
) (
    input  logic              ap_clk,
    input  logic              ap_rst,
    input  logic              ap_start,
    output logic              ap_done,
    output logic              ap_idle,
    output logic              ap_ready,
    input  logic [KEY_W-1:0]  locking_key,
    input  logic [N*DW-1:0]   lane_a,
    input  logic [N*DW-1:0]   lane_b,
    input  logic [AW-1:0]     acc_in,
    output logic [AW-1:0]     out_acc,
    output logic              out_acc_ap_vld
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_MAC  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [KEY_W-1:0]   key_q, key_d;
    logic [N*DW-1:0]    a_q, a_d;
    logic [N*DW-1:0]    b_q, b_d;
    logic [AW-1:0]      acc_q, acc_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [AW-1:0]      out_acc_q, out_acc_d;
    logic               done_q, done_d;

    logic [KEY_W-1:0]   mis;
    logic               last_lane;
    logic signed [DW-1:0]   a_sel, b_sel;
    logic signed [2*DW-1:0] prod;
    logic [AW-1:0]      prod_ext;
    logic [AW-1:0]      out_mask;

    // Mismatch vector: zero when the latched key is correct.
    assign mis       = key_q ^ KEY_VALUE;
    assign last_lane = (cnt_q == CW'(N - 1));

    assign a_sel    = a_q[int'(cnt_q)*DW +: DW];
    assign b_sel    = b_q[int'(cnt_q)*DW +: DW];
    assign prod     = a_sel * b_sel;
    assign prod_ext = {{(AW - 2*DW){prod[2*DW-1]}}, prod};
    assign out_mask = AW'({mis[KEY_W-1:2], 2'b00});

    // State register
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; each transition is split on a key bit with both
    // arms leading to a legal state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (ap_start) begin
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                if (mis[0]) state_d = S_MAC;
                else        state_d = S_MAC;
            end
            S_MAC: begin
                if (last_lane) begin
                    if (mis[1]) state_d = S_DONE;
                    else        state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (mis[KEY_W-1]) state_d = S_IDLE;
                else              state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath next values
    always_comb begin
        key_d     = key_q;
        a_d       = a_q;
        b_d       = b_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        out_acc_d = out_acc_q;
        case (state_q)
            S_IDLE: begin
                if (ap_start) key_d = locking_key;
            end
            S_LOAD: begin
                a_d   = lane_a;
                b_d   = lane_b;
                acc_d = acc_in;
                // A wrong key bit 0 skips lane 0.
                if (mis[0]) cnt_d = CW'(1);
                else        cnt_d = '0;
            end
            S_MAC: begin
                if (mis[1]) acc_d = acc_q - prod_ext;
                else        acc_d = acc_q + prod_ext;
                cnt_d = cnt_q + CW'(1);
                // Result is loaded on the edge entering S_DONE so that it
                // is already valid while the vld pulse is high.
                if (last_lane) out_acc_d = acc_d ^ out_mask;
            end
            default: ;
        endcase
    end

    assign done_d = (state_d == S_DONE);

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            key_q     <= '0;
            a_q       <= '0;
            b_q       <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            out_acc_q <= '0;
            done_q    <= 1'b0;
        end else begin
            key_q     <= key_d;
            a_q       <= a_d;
            b_q       <= b_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            out_acc_q <= out_acc_d;
            done_q    <= done_d;
        end
    end

    // Outputs
    always_comb begin
        ap_idle        = (state_q == S_IDLE);
        ap_done        = done_q;
        ap_ready       = done_q;
        out_acc_ap_vld = done_q;
        out_acc        = out_acc_q;
    end

endmodule

// File: tb/tb_hls_macc_n_obf.sv
`timescale 1ns/1ps

module tb_hls_macc_n_obf;

    logic        ap_clk = 1'b0;
    logic        ap_rst;
    logic        ap_start;
    logic        ap_done, ap_idle, ap_ready, out_acc_ap_vld;
    logic [7:0]  locking_key;
    logic [31:0] lane_a, lane_b, acc_in;
    logic [31:0] out_acc;

    hls_macc_n_obf #(.N(4), .DW(8), .AW(32), .KEY_W(8), .KEY_VALUE(8'hA5)) dut (
        .ap_clk(ap_clk), .ap_rst(ap_rst), .ap_start(ap_start),
        .ap_done(ap_done), .ap_idle(ap_idle), .ap_ready(ap_ready),
        .locking_key(locking_key), .lane_a(lane_a), .lane_b(lane_b),
        .acc_in(acc_in), .out_acc(out_acc), .out_acc_ap_vld(out_acc_ap_vld)
    );

    always #5 ap_clk = ~ap_clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always @(posedge ap_clk) cyc <= cyc + 1;

    task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: result and latency from the behavioural rules.
    function automatic logic [31:0] model_res(input logic [7:0] key, input logic [31:0] la,
                                              input logic [31:0] lb, input logic [31:0] acc0);
        logic [7:0] m;
        int acc;
        int p;
        m = key ^ 8'hA5;
        acc = int'(acc0);
        for (int i = (m[0] ? 1 : 0); i < 4; i++) begin
            p = int'($signed(la[i*8 +: 8])) * int'($signed(lb[i*8 +: 8]));
            acc = m[1] ? acc - p : acc + p;
        end
        return 32'(acc) ^ {24'd0, m[7:2], 2'b00};
    endfunction

    function automatic int model_lat(input logic [7:0] key);
        logic [7:0] m;
        m = key ^ 8'hA5;
        return m[0] ? 5 : 6;
    endfunction

    typedef struct {
        int          due;
        logic [31:0] res;
    } exp_t;

    exp_t        expq[$];
    logic [31:0] held = 32'd0;

    // Compare process: every cycle, away from the active edge.
    always @(negedge ap_clk) begin
        bit   exp_done;
        bit   exp_idle;
        exp_t e;
        if (ap_rst) begin
            expq.delete();
            held = 32'd0;
            chk(ap_idle == 1'b1, "rst_idle", 32'(ap_idle), 32'd1);
            chk(out_acc_ap_vld == 1'b0, "rst_vld", 32'(out_acc_ap_vld), 32'd0);
            chk(out_acc == 32'd0, "rst_out_acc", out_acc, 32'd0);
        end else begin
            if (expq.size() > 0 && expq[0].due < cyc) begin
                chk(1'b0, "missed_done", 32'(expq[0].due), 32'(cyc));
                void'(expq.pop_front());
            end
            exp_done = (expq.size() > 0 && expq[0].due == cyc);
            exp_idle = (expq.size() == 0) && !exp_done;
            chk(out_acc_ap_vld == exp_done, "vld", 32'(out_acc_ap_vld), 32'(exp_done));
            chk(ap_done == exp_done, "done", 32'(ap_done), 32'(exp_done));
            chk(ap_ready == exp_done, "ready", 32'(ap_ready), 32'(exp_done));
            chk(ap_idle == exp_idle, "idle", 32'(ap_idle), 32'(exp_idle));
            if (exp_done) begin
                held = expq[0].res;
                void'(expq.pop_front());
            end
            chk(out_acc == held, "out_acc", out_acc, held);
            if (ap_idle && ap_start) begin
                e.due = cyc + model_lat(locking_key);
                e.res = model_res(locking_key, lane_a, lane_b, acc_in);
                expq.push_back(e);
            end
        end
    end

    task automatic step();
        @(posedge ap_clk);
        #2;
    endtask

    int c0;

    task automatic start_op(input logic [7:0] key, input logic [31:0] la,
                            input logic [31:0] lb, input logic [31:0] acc0);
        int k;
        k = 0;
        while (!ap_idle && k < 50) begin
            step();
            k++;
        end
        if (!ap_idle) chk(1'b0, "idle_timeout", 32'(ap_idle), 32'd1);
        locking_key = key;
        lane_a = la;
        lane_b = lb;
        acc_in = acc0;
        ap_start = 1'b1;
        c0 = cyc;
        step();
        ap_start = 1'b0;
    endtask

    task automatic wait_done(output logic [31:0] res, output int lat);
        int k;
        k = 0;
        while (!ap_done && k < 40) begin
            step();
            k++;
        end
        if (!ap_done) chk(1'b0, "done_timeout", 32'(ap_done), 32'd1);
        res = out_acc;
        lat = cyc - c0;
    endtask

    task automatic run_op(input logic [7:0] key, input logic [31:0] la, input logic [31:0] lb,
                          input logic [31:0] acc0, input logic [31:0] exp_res,
                          input int exp_lat, input string name);
        logic [31:0] r;
        int lat;
        start_op(key, la, lb, acc0);
        wait_done(r, lat);
        chk(r == exp_res, name, r, exp_res);
        chk(lat == exp_lat, {name, "_latency"}, 32'(lat), 32'(exp_lat));
        step();
    endtask

    localparam logic [31:0] T1A = {8'd4, 8'd3, 8'd2, 8'd1};
    localparam logic [31:0] T1B = {8'd8, 8'd7, 8'd6, 8'd5};
    localparam logic [31:0] T2A = {8'd0, 8'd0, 8'h7F, 8'h80};
    localparam logic [31:0] T2B = {8'd0, 8'd0, 8'h80, 8'h80};

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] r;
        int lat;
        ap_rst = 1'b1;
        ap_start = 1'b0;
        locking_key = 8'h00;
        lane_a = '0;
        lane_b = '0;
        acc_in = '0;
        repeat (3) step();
        chk(ap_idle == 1'b1, "reset_idle_lit", 32'(ap_idle), 32'd1);
        chk(out_acc == 32'd0, "reset_out_lit", out_acc, 32'd0);
        ap_rst = 1'b0;
        step();

        // Pin the model with hand-computed values.
        chk(model_res(8'hA5, T1A, T1B, 32'd10) == 32'd80, "model_t1", model_res(8'hA5, T1A, T1B, 32'd10), 32'd80);
        chk(model_res(8'hA4, T1A, T1B, 32'd10) == 32'd75, "model_t3a", model_res(8'hA4, T1A, T1B, 32'd10), 32'd75);
        chk(model_res(8'hA7, T1A, T1B, 32'd10) == 32'hFFFFFFC4, "model_t3b", model_res(8'hA7, T1A, T1B, 32'd10), 32'hFFFFFFC4);
        chk(model_res(8'h25, T1A, T1B, 32'd10) == 32'd208, "model_t4", model_res(8'h25, T1A, T1B, 32'd10), 32'd208);

        run_op(8'hA5, T1A, T1B, 32'd10, 32'd80, 6, "t1");
        run_op(8'hA5, T2A, T2B, 32'd0, 32'd128, 6, "t2");
        run_op(8'hA4, T1A, T1B, 32'd10, 32'd75, 5, "t3_m0");
        run_op(8'hA7, T1A, T1B, 32'd10, 32'hFFFFFFC4, 6, "t3_m1");
        run_op(8'h25, T1A, T1B, 32'd10, 32'd208, 6, "t4");

        // Key switched mid-operation must be ignored.
        start_op(8'h25, T1A, T1B, 32'd10);
        step();
        locking_key = 8'h00;
        wait_done(r, lat);
        chk(r == 32'd208, "t4_key_switch", r, 32'd208);
        step();

        run_op(8'hA5, 32'h1, 32'h1, 32'h7FFFFFFF, 32'h80000000, 6, "t5_wrap");

        // Reset in the 2nd S_MAC cycle.
        start_op(8'hA5, T1A, T1B, 32'd10);
        step();
        step();
        ap_rst = 1'b1;
        step();
        chk(ap_idle == 1'b1, "t6_idle", 32'(ap_idle), 32'd1);
        chk(out_acc == 32'd0, "t6_out", out_acc, 32'd0);
        chk(out_acc_ap_vld == 1'b0, "t6_vld", 32'(out_acc_ap_vld), 32'd0);
        ap_rst = 1'b0;
        repeat (8) step();
        run_op(8'hA5, T1A, T1B, 32'd10, 32'd80, 6, "t6_after_rst");

        // ap_start held high: back-to-back operations.
        locking_key = 8'hA5;
        lane_a = T1A;
        lane_b = T1B;
        acc_in = 32'd10;
        ap_start = 1'b1;
        c0 = cyc;
        step();
        for (int j = 0; j < 3; j++) begin
            wait_done(r, lat);
            chk(r == 32'd80, "b2b_res", r, 32'd80);
            if (j == 2) ap_start = 1'b0;
            step();
        end

        // Randomized operations, checked by the compare process.
        for (int n = 0; n < 40; n++) begin
            logic [7:0] key;
            key = ($urandom_range(0, 1) == 1) ? 8'hA5 : 8'($urandom);
            start_op(key, $urandom, $urandom, $urandom);
            step();
            lane_a = $urandom;
            lane_b = $urandom;
            acc_in = $urandom;
            if ($urandom_range(0, 3) == 0) locking_key = 8'($urandom);
            wait_done(r, lat);
            repeat ($urandom_range(1, 3)) step();
        end

        repeat (10) step();
        chk(expq.size() == 0, "queue_drained", 32'(expq.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
